// File: rtl/tick_scheduler_pkg.sv
// Shared types and default constants for the tick scheduler.
// Optional feature macro: TICK_SCHEDULER_ONESHOT_EN (per-channel one-shot mode).
package tick_scheduler_pkg;

  // Configuration handshake states: IDLE accepts a write, APPLY commits it.
  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } cfg_state_e;

  // 1 us base strobe at a 33 MHz clock.
  localparam int unsigned DEF_PRESCALE = 33;
  // Wide enough for periods of over a minute in microsecond strobes.
  localparam int unsigned DEF_CNT_W    = 26;
  localparam int unsigned DEF_NUM_CH   = 4;

endpackage : tick_scheduler_pkg

// File: rtl/tick_channel.sv
// One tick channel: stored configuration, period counter and tick pulse.
// Optional feature macro: TICK_SCHEDULER_ONESHOT_EN adds a one-shot flag that
// drops the enable on the channel's tick.
module tick_channel
  import tick_scheduler_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             strobe_i,
  input  logic             wr_i,
  input  logic             wr_en_i,
  input  logic [CNT_W-1:0] wr_period_i,
`ifdef TICK_SCHEDULER_ONESHOT_EN
  input  logic             wr_oneshot_i,
`endif
  output logic             tick_o,
  output logic             busy_o
);

  logic             en_q, en_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             busy_q;
  logic             armed;
  logic             terminal;
`ifdef TICK_SCHEDULER_ONESHOT_EN
  logic             oneshot_q, oneshot_d;
`endif

  // A period of zero parks the channel even when it is enabled.
  assign armed    = en_q && (period_q != '0);
  assign terminal = (cnt_q == (period_q - CNT_W'(1)));

  // Next-state: a configuration write wins over the strobe, otherwise count.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    en_d      = en_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    tick_d    = 1'b0;
`ifdef TICK_SCHEDULER_ONESHOT_EN
    oneshot_d = oneshot_q;
`endif
    if (wr_i) begin
      // The commit cycle swallows any strobe and restarts the count.
      en_d      = wr_en_i;
      period_d  = wr_period_i;
      cnt_d     = '0;
`ifdef TICK_SCHEDULER_ONESHOT_EN
      oneshot_d = wr_oneshot_i;
`endif
    end else if (strobe_i && armed) begin
      if (terminal) begin
        tick_d = 1'b1;
        cnt_d  = '0;
`ifdef TICK_SCHEDULER_ONESHOT_EN
        if (oneshot_q) begin
          en_d = 1'b0;
        end
`endif
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Channel registers; busy is a registered copy of the armed condition.
  always_ff @(posedge clk_i) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      en_q      <= 1'b0;
      period_q  <= '0;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef TICK_SCHEDULER_ONESHOT_EN
      oneshot_q <= 1'b0;
`endif
    end else begin
      en_q      <= en_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      busy_q    <= armed;
`ifdef TICK_SCHEDULER_ONESHOT_EN
      oneshot_q <= oneshot_d;
`endif
    end
  end

  assign tick_o = tick_q;
  assign busy_o = busy_q;

endmodule : tick_channel

// File: rtl/tick_scheduler.sv
// Multi-channel tick scheduler: a free-running prescaler produces a base
// strobe, NUM_CH independent channels count strobes and pulse tick_out, and a
// two-state handshake FSM commits one configuration write every two cycles.
// Optional feature macro: TICK_SCHEDULER_ONESHOT_EN enables one-shot channels;
// without it cfg_oneshot is ignored and every channel is periodic.
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CH   = DEF_NUM_CH,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned PRESCALE = DEF_PRESCALE
) (
  input  logic                      clk_in,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]          cfg_period,
  input  logic                      cfg_en,
  input  logic                      cfg_oneshot,
  output logic [NUM_CH-1:0]         tick_out,
  output logic [NUM_CH-1:0]         busy
);

  localparam int unsigned CH_W = $clog2(NUM_CH);
  localparam int unsigned PS_W = $clog2(PRESCALE);

  // ---------------------------------------------------------------- prescaler
  logic [PS_W-1:0] presc_q, presc_d;
  logic            strobe;

  assign strobe = (presc_q == PS_W'(PRESCALE - 1));

  // Wrap at PRESCALE-1; configuration traffic never disturbs the phase.
  always_comb begin
    presc_d = strobe ? '0 : presc_q + PS_W'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // --------------------------------------------------------------- config FSM
  cfg_state_e state_q, state_d;
  logic       accept;
  logic       apply;

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    accept    = 1'b0;
    apply     = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          accept  = 1'b1;
          state_d = APPLY;
        end
      end
      APPLY: begin
        apply   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register; reset here also drops a write caught mid-APPLY.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ------------------------------------------------------ latched write fields
  logic [CH_W-1:0]  lat_ch_q;
  logic [CNT_W-1:0] lat_period_q;
  logic             lat_en_q;
`ifdef TICK_SCHEDULER_ONESHOT_EN
  logic             lat_oneshot_q;
`else
  // One-shot support is not built; the port is intentionally left unread.
  logic             unused_cfg_oneshot;
  assign unused_cfg_oneshot = cfg_oneshot;
`endif

  // Capture cfg_* only on the accepting cycle.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      lat_ch_q      <= '0;
      lat_period_q  <= '0;
      lat_en_q      <= 1'b0;
`ifdef TICK_SCHEDULER_ONESHOT_EN
      lat_oneshot_q <= 1'b0;
`endif
    end else if (accept) begin
      lat_ch_q      <= cfg_ch;
      lat_period_q  <= cfg_period;
      lat_en_q      <= cfg_en;
`ifdef TICK_SCHEDULER_ONESHOT_EN
      lat_oneshot_q <= cfg_oneshot;
`endif
    end
  end

  // ----------------------------------------------------------------- channels
  // An out-of-range channel index matches no instance, so the write is
  // consumed by the handshake and discarded.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic wr;
    assign wr = apply && (lat_ch_q == CH_W'(g));

    tick_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i        (clk_in),
      .rst_i        (rst),
      .strobe_i     (strobe),
      .wr_i         (wr),
      .wr_en_i      (lat_en_q),
      .wr_period_i  (lat_period_q),
`ifdef TICK_SCHEDULER_ONESHOT_EN
      .wr_oneshot_i (lat_oneshot_q),
`endif
      .tick_o       (tick_out[g]),
      .busy_o       (busy[g])
    );
  end

endmodule : tick_scheduler

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: a strobe-counting reference model
// checked every cycle, directed scenarios with literal expectations, and a
// randomized configuration/reset phase.
module tb_tick_scheduler;

  localparam int NUM_CH   = 3;
  localparam int CNT_W    = 8;
  localparam int PRESCALE = 4;
  localparam int CH_W     = $clog2(NUM_CH);

  logic              clk_in = 1'b0;
  logic              rst = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_period = '0;
  logic              cfg_en = 1'b0;
  logic              cfg_oneshot = 1'b0;
  logic [NUM_CH-1:0] tick_out;
  logic [NUM_CH-1:0] busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  tick_scheduler #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .PRESCALE(PRESCALE)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_en     (cfg_en),
    .cfg_oneshot(cfg_oneshot),
    .tick_out   (tick_out),
    .busy       (busy)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------ reference model
  // Channels are described by strobes seen since their last configuration:
  // a tick is due whenever that count reaches a multiple of the period.
  bit                m_valid = 1'b0;
  int                m_k;
  bit                m_pend;
  int                m_pch, m_pper;
  bit                m_pen, m_pos;
  bit                m_en   [NUM_CH];
  int                m_per  [NUM_CH];
  bit                m_os   [NUM_CH];
  int                m_seen [NUM_CH];
  logic [NUM_CH-1:0] m_tick, m_busy;
  bit                m_ready;

  always @(posedge clk_in) begin : p_model
    bit strobe;
    bit was_pend;
    if (rst) begin
      m_valid = 1'b1;
      m_k     = 0;
      m_pend  = 1'b0;
      m_tick  = '0;
      m_busy  = '0;
      m_ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        m_en[i] = 1'b0; m_per[i] = 0; m_os[i] = 1'b0; m_seen[i] = 0;
      end
    end else if (m_valid) begin
      strobe   = (m_k % PRESCALE) == PRESCALE - 1;
      m_k++;
      was_pend = m_pend;
      for (int i = 0; i < NUM_CH; i++) begin
        m_busy[i] = m_en[i] && (m_per[i] != 0);
        m_tick[i] = 1'b0;
        if (was_pend && m_pch == i) begin
          m_en[i]   = m_pen;
          m_per[i]  = m_pper;
`ifdef TICK_SCHEDULER_ONESHOT_EN
          m_os[i]   = m_pos;
`else
          m_os[i]   = 1'b0;
`endif
          m_seen[i] = 0;
        end else if (strobe && m_en[i] && m_per[i] != 0) begin
          m_seen[i]++;
          if (m_seen[i] % m_per[i] == 0) begin
            m_tick[i] = 1'b1;
            if (m_os[i]) m_en[i] = 1'b0;
          end
        end
      end
      if (was_pend) begin
        m_pend = 1'b0;
      end else if (cfg_valid) begin
        m_pend = 1'b1;
        m_pch  = int'(cfg_ch);
        m_pper = int'(cfg_period);
        m_pen  = cfg_en;
        m_pos  = cfg_oneshot;
      end
      m_ready = !m_pend;
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk_in) begin
    if (m_valid && !rst) begin
      check("model_tick",  32'(tick_out),  32'(m_tick));
      check("model_busy",  32'(busy),      32'(m_busy));
      check("model_ready", 32'(cfg_ready), 32'(m_ready));
    end
  end

  // ------------------------------------------------------------ helpers
  task automatic reset_dut();
    @(negedge clk_in);
    rst = 1'b1; cfg_valid = 1'b0;
    @(negedge clk_in);
    rst = 1'b0;
  endtask

  task automatic write_cfg(input int ch, input int per, input bit en, input bit os);
    int guard = 0;
    while (!cfg_ready && guard < 10) begin
      @(negedge clk_in);
      guard++;
    end
    cfg_valid = 1'b1; cfg_ch = CH_W'(ch); cfg_period = CNT_W'(per);
    cfg_en = en; cfg_oneshot = os;
    @(negedge clk_in);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_tick(input int ch, output int t);
    int n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!tick_out[ch] && n < 200);
    check("tick_seen", 32'(tick_out[ch]), 32'd1);
    t = cyc;
  endtask

  task automatic count_ticks(input int ch, input int ncyc, output int cnt);
    cnt = 0;
    repeat (ncyc) begin
      @(negedge clk_in);
      if (tick_out[ch]) cnt++;
    end
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    int t0, t1, t2, t3, cnt;

    rst = 1'b1;
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    check("rst_tick",  32'(tick_out),  32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);

    // Periodic: PRESCALE 4 x period 3 = 12 cycles between 1-cycle ticks.
    write_cfg(0, 3, 1'b1, 1'b0);
    wait_tick(0, t0);
    @(negedge clk_in);
    check("tick_width", 32'(tick_out[0]), 32'd0);
    wait_tick(0, t1);
    wait_tick(0, t2);
    check("period12_a", 32'(t1 - t0), 32'd12);
    check("period12_b", 32'(t2 - t1), 32'd12);
    check("busy_armed", 32'(busy[0]), 32'd1);

    // Back-to-back writes: ready 1,0,1,0 and both channels armed.
    reset_dut();
    check("thr_ready0", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1; cfg_ch = 0; cfg_period = 3; cfg_en = 1'b1; cfg_oneshot = 1'b0;
    @(negedge clk_in);
    check("thr_ready1", 32'(cfg_ready), 32'd0);
    cfg_ch = 1; cfg_period = 4;
    @(negedge clk_in);
    check("thr_ready2", 32'(cfg_ready), 32'd1);
    @(negedge clk_in);
    check("thr_ready3", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    repeat (2) @(negedge clk_in);
    check("thr_busy", 32'(busy), 32'b011);

    // Write accepted on the terminal strobe: old tick, then every 5 strobes.
    reset_dut();
    write_cfg(0, 2, 1'b1, 1'b0);
    wait_tick(0, t0);
    repeat (7) @(negedge clk_in);
    cfg_valid = 1'b1; cfg_ch = 0; cfg_period = 5; cfg_en = 1'b1; cfg_oneshot = 1'b0;
    @(negedge clk_in);
    cfg_valid = 1'b0;
    check("old_tick", 32'(tick_out[0]), 32'd1);
    t1 = cyc;
    check("old_tick_gap", 32'(t1 - t0), 32'd8);
    wait_tick(0, t2);
    wait_tick(0, t3);
    check("new_period_a", 32'(t2 - t1), 32'd20);
    check("new_period_b", 32'(t3 - t2), 32'd20);

    // One-shot request.
    reset_dut();
    write_cfg(0, 2, 1'b1, 1'b1);
    wait_tick(0, t0);
`ifdef TICK_SCHEDULER_ONESHOT_EN
    check("os_busy_at_tick", 32'(busy[0]), 32'd1);
    @(negedge clk_in);
    check("os_busy_after", 32'(busy[0]), 32'd0);
    count_ticks(0, 40, cnt);
    check("os_no_more_ticks", 32'(cnt), 32'd0);
`else
    wait_tick(0, t1);
    check("os_off_periodic", 32'(t1 - t0), 32'd8);
`endif

    // Out-of-range channel is accepted and discarded.
    reset_dut();
    write_cfg(3, 1, 1'b1, 1'b0);
    count_ticks(0, 20, cnt);
    check("oor_busy",  32'(busy),      32'd0);
    check("oor_ready", 32'(cfg_ready), 32'd1);

    // Simultaneous ticks on all channels.
    write_cfg(0, 1, 1'b1, 1'b0);
    write_cfg(1, 1, 1'b1, 1'b0);
    write_cfg(2, 1, 1'b1, 1'b0);
    wait_tick(0, t0);
    check("all_tick", 32'(tick_out), 32'b111);

    // Reset mid-count clears everything.
    repeat (3) @(negedge clk_in);
    rst = 1'b1;
    @(negedge clk_in);
    check("midrst_tick",  32'(tick_out),  32'd0);
    check("midrst_busy",  32'(busy),      32'd0);
    check("midrst_ready", 32'(cfg_ready), 32'd1);
    rst = 1'b0;

    // Reset during APPLY drops the pending write.
    @(negedge clk_in);
    cfg_valid = 1'b1; cfg_ch = 0; cfg_period = 1; cfg_en = 1'b1;
    @(negedge clk_in);
    cfg_valid = 1'b0; rst = 1'b1;
    @(negedge clk_in);
    rst = 1'b0;
    repeat (10) @(negedge clk_in);
    check("apply_rst_busy", 32'(busy), 32'd0);

    // Period zero: enabled yet never armed, no ticks over 100 strobes.
    write_cfg(0, 0, 1'b1, 1'b0);
    count_ticks(0, 100 * PRESCALE, cnt);
    check("p0_ticks", 32'(cnt),  32'd0);
    check("p0_busy",  32'(busy), 32'd0);

    // Randomized writes and occasional resets against the model.
    reset_dut();
    repeat (3000) begin
      @(negedge clk_in);
      cfg_valid   = ($urandom_range(0, 2) == 0);
      cfg_ch      = CH_W'($urandom_range(0, 3));
      cfg_period  = CNT_W'($urandom_range(0, 5));
      cfg_en      = ($urandom_range(0, 4) != 0);
      cfg_oneshot = ($urandom_range(0, 3) == 0);
      rst         = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk_in);
    rst = 1'b0; cfg_valid = 1'b0;
    repeat (5) @(negedge clk_in);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_tick_scheduler
